aes_encrypt_iter: RTL and testbench

// - Iterative AES-128/192/256 encryption core: one round per clock, reusing the existing keyExpansion, round and last_round blocks.
// - Successor to the free-running encrypt block. Adds:
//   - a derived NR, so NK alone selects the key size;
//   - valid/ready handshakes on input and output, with output backpressure;
//   - a per-block latched key;
//   - asynchronous reset.
// - Sits between the host data path and any downstream consumer of ciphertext blocks.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_cipher_blocks.sv | 64 ++++++
 rtl/aes_round_key_sel.sv | 22 ++
 rtl/aes_encrypt_iter.sv | 119 +++++++++++
 tb/tb_aes_encrypt_iter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level transforms.
// Used by the iterative encryption core and its helper blocks.
package aes_pkg;

   localparam int AES_BLK = 128;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      logic [7:0] v;
      x = a;
      v = 8'h01;
      for (int i = 1; i < 8; i++) begin
         x = gmul(x, x);
         v = gmul(v, x);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   // Byte 4c+r sits at row r, column c; row r rotates left by r.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_cipher_blocks.sv
// Combinational AES building blocks: key schedule, full round and
// final round (no MixColumns).
module aes_key_expansion
   import aes_pkg::*;
#(
   parameter int NK = 4,
   parameter int NR = nr_of(NK)
) (
   input  logic [NK*32-1:0]           key,
   output logic [0:(NR+1)*AES_BLK-1]  schedule
);

   localparam int NW = 4 * (NR + 1);

   function automatic logic [0:NW*32-1] expand(input logic [NK*32-1:0] k);
      logic [31:0] w [NW];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [0:NW*32-1] s;
      rc = 8'h01;
      for (int i = 0; i < NK; i++)
         w[i] = k[NK*32-1-32*i -: 32];
      for (int i = NK; i < NW; i++) begin
         t = w[i-1];
         if (i % NK == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end else if (NK > 6 && i % NK == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-NK] ^ t;
      end
      for (int i = 0; i < NW; i++)
         s[32*i +: 32] = w[i];
      return s;
   endfunction

   assign schedule = expand(key);

endmodule

module aes_round
   import aes_pkg::*;
(
   input  logic [AES_BLK-1:0] state,
   input  logic [AES_BLK-1:0] round_key,
   output logic [AES_BLK-1:0] result
);

   assign result = mix_columns(shift_rows(sub_bytes(state))) ^ round_key;

endmodule

module aes_last_round
   import aes_pkg::*;
(
   input  logic [AES_BLK-1:0] state,
   input  logic [AES_BLK-1:0] round_key,
   output logic [AES_BLK-1:0] result
);

   assign result = shift_rows(sub_bytes(state)) ^ round_key;

endmodule

// File: rtl/aes_round_key_sel.sv
// Picks the 128-bit round key for round_cnt out of the full schedule.
// Word 0 of the schedule occupies the lowest (MSB-first) indices.
module aes_round_key_sel
   import aes_pkg::*;
#(
   parameter int NR = 10,
   parameter int CW = $clog2(NR + 1)
) (
   input  logic [CW-1:0]              round_cnt,
   input  logic [0:(NR+1)*AES_BLK-1]  schedule,
   output logic [AES_BLK-1:0]         round_key
);

   // Constant-index mux over the NR+1 round keys.
   always_comb begin
      round_key = '0;
      for (int r = 0; r <= NR; r++)
         if (round_cnt == CW'(r))
            round_key = schedule[r*AES_BLK +: AES_BLK];
   end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption, one round per clock, with
// valid/ready handshakes and a key latched per block.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [AES_BLK-1:0] in_data,
   input  logic [NK*32-1:0]   in_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [AES_BLK-1:0] out_data
);

   localparam int NR = nr_of(NK);
   localparam int CW = $clog2(NR + 1);
   localparam logic [CW-1:0] LAST = CW'(NR);

   fsm_t                      fsm;
   logic [CW-1:0]             round_cnt;
   logic [AES_BLK-1:0]        state_q;
   logic [NK*32-1:0]          key_q;
   logic [0:(NR+1)*AES_BLK-1] sched_q;
   logic [0:(NR+1)*AES_BLK-1] sched_in;
   logic [AES_BLK-1:0]        rk;
   logic [AES_BLK-1:0]        rk0_in;
   logic [AES_BLK-1:0]        round_out;
   logic [AES_BLK-1:0]        last_out;

   aes_key_expansion #(.NK(NK), .NR(NR)) u_kexp_q (
      .key      (key_q),
      .schedule (sched_q)
   );

   aes_key_expansion #(.NK(NK), .NR(NR)) u_kexp_in (
      .key      (in_key),
      .schedule (sched_in)
   );

   aes_round_key_sel #(.NR(NR), .CW(CW)) u_sel_q (
      .round_cnt (round_cnt),
      .schedule  (sched_q),
      .round_key (rk)
   );

   aes_round_key_sel #(.NR(NR), .CW(CW)) u_sel_in (
      .round_cnt ('0),
      .schedule  (sched_in),
      .round_key (rk0_in)
   );

   aes_round u_round (
      .state     (state_q),
      .round_key (rk),
      .result    (round_out)
   );

   aes_last_round u_last (
      .state     (state_q),
      .round_key (rk),
      .result    (last_out)
   );

   assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
   assign out_data = state_q;

   // Accept / iterate / present FSM with registered out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         round_cnt <= '0;
         state_q   <= '0;
         key_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  key_q     <= in_key;
                  state_q   <= in_data ^ rk0_in;
                  round_cnt <= CW'(1);
                  fsm       <= RUN;
               end
            end
            RUN: begin
               if (round_cnt == LAST) begin
                  state_q   <= last_out;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  state_q   <= round_out;
                  round_cnt <= round_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  fsm       <= IDLE;
                  if (in_valid) begin
                     key_q     <= in_key;
                     state_q   <= in_data ^ rk0_in;
                     round_cnt <= CW'(1);
                     fsm       <= RUN;
                  end
               end
            end
            default: begin
               fsm       <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer vectors,
// handshake timing model, backpressure, back-to-back and reset.
module tb_aes_encrypt_iter;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] C4 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [191:0] K6 =
      192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] K8 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam int NR4 = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] in_data = '0;
   logic [127:0] in_key = '0;
   logic         in_ready, out_valid;
   logic [127:0] out_data;

   logic         v6 = 1'b0, v8 = 1'b0, one = 1'b1;
   logic [191:0] k6 = '0;
   logic [255:0] k8 = '0;
   logic         r6, ov6, r8, ov8;
   logic [127:0] od6, od8;

   aes_encrypt_iter #(.NK(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   aes_encrypt_iter #(.NK(6)) dut6 (
      .clk(clk), .rst(rst),
      .in_valid(v6), .in_ready(r6),
      .in_data(in_data), .in_key(k6),
      .out_valid(ov6), .out_ready(one),
      .out_data(od6)
   );

   aes_encrypt_iter #(.NK(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(v8), .in_ready(r8),
      .in_data(in_data), .in_key(k8),
      .out_valid(ov8), .out_ready(one),
      .out_data(od8)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Known-answer table: the reference for any accepted block.
   function automatic bit golden(input logic [127:0] k,
                                 input logic [127:0] p,
                                 output logic [127:0] c);
      c = 'x;
      if (k == K1 && p == P1) c = C1;
      else if (k == K2 && p == P2) c = C2;
      else if (k == K2 && p == P3) c = C3;
      else if (k == '0 && p == '0) c = C4;
      else return 1'b0;
      return 1'b1;
   endfunction

   // Transaction-level model: one block in flight, result due NR edges
   // after its accept edge, released on the first out_ready cycle.
   int           cyc = 0;
   bit           m_has = 1'b0;
   logic [127:0] m_ct = '0;
   int           m_done = 0;
   int           acc_cyc[$];
   logic [127:0] got_q[$];

   always @(posedge clk) begin
      bit ev, er, ok;
      if (rst) begin
         m_has = 1'b0;
      end else begin
         ev = m_has && (cyc >= m_done);
         er = !m_has || (ev && out_ready);
         if (ev && out_ready) m_has = 1'b0;
         if (in_valid && er) begin
            ok = golden(in_key, in_data, m_ct);
            chk("accept_known_vector", ok, 1);
            m_has  = 1'b1;
            m_done = cyc + 1 + NR4;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit ev, er;
      if (rst) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_data", out_data, 0);
      end else begin
         ev = m_has && (cyc >= m_done);
         er = !m_has || (ev && out_ready);
         chk("out_valid", out_valid, ev);
         chk("in_ready", in_ready, er);
         if (ev) chk("out_data", out_data, m_ct);
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (out_valid && out_ready) got_q.push_back(out_data);
      end
   end

   task automatic wait_valid(output int n, input int limit);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid && n < limit);
   endtask

   task automatic wait_ready(input int limit);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
   endtask

   int n, n4, n6, n8, q0;
   logic [127:0] bk [3];
   logic [127:0] bp [3];
   logic [127:0] bc [3];

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bk[0] = K1; bp[0] = P1; bc[0] = C1;
      bk[1] = K2; bp[1] = P2; bc[1] = C2;
      bk[2] = '0; bp[2] = '0; bc[2] = C4;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      rst = 1'b0;

      // Key-size vectors on all three instances at once.
      in_key = K1; in_data = P1; k6 = K6; k8 = K8;
      in_valid = 1'b1; v6 = 1'b1; v8 = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; v6 = 1'b0; v8 = 1'b0;
      fork
         begin
            n4 = 0;
            do begin @(posedge clk); #1; n4++; end
            while (!out_valid && n4 < 40);
            chk("lat_nk4", n4, 10);
            chk("ct_nk4", out_data, C1);
         end
         begin
            n6 = 0;
            do begin @(posedge clk); #1; n6++; end
            while (!ov6 && n6 < 40);
            chk("lat_nk6", n6, 12);
            chk("ct_nk6", od6, C6);
         end
         begin
            n8 = 0;
            do begin @(posedge clk); #1; n8++; end
            while (!ov8 && n8 < 40);
            chk("lat_nk8", n8, 14);
            chk("ct_nk8", od8, C8);
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Backpressure with a new block waiting to be accepted.
      out_ready = 1'b0;
      in_key = K2; in_data = P2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n, 40);
      chk("lat_bp", n, 10);
      in_data = P3; in_valid = 1'b1;
      q0 = got_q.size();
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_data", out_data, C2);
         @(posedge clk); #1;
      end
      chk("bp_no_handshake", got_q.size() - q0, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_one_handshake", got_q.size() - q0, 1);
      if (got_q.size() > q0) chk("bp_hs_data", got_q[q0], C2);
      chk("bp_done_accept_busy", in_ready, 0);
      wait_valid(n, 40);
      chk("lat_done_accept", n, 10);
      chk("ct_done_accept", out_data, C3);
      @(posedge clk); #1;

      // Back-to-back blocks; inputs scrambled while the core is busy.
      got_q.delete();
      acc_cyc.delete();
      in_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         in_key = bk[b]; in_data = bp[b];
         wait_ready(30);
         @(posedge clk); #1;
         if (b < 2) begin
            repeat (5) begin
               in_key  = {$urandom, $urandom, $urandom, $urandom};
               in_data = {$urandom, $urandom, $urandom, $urandom};
               @(posedge clk); #1;
            end
         end
      end
      in_valid = 1'b0;
      wait_valid(n, 40);
      @(posedge clk); #1;
      chk("b2b_count", got_q.size(), 3);
      for (int b = 0; b < 3; b++)
         if (b < got_q.size()) chk("b2b_data", got_q[b], bc[b]);
      chk("b2b_accepts", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 11);
         chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 11);
      end

      // Reset in the middle of round 5, then a clean block.
      in_key = K1; in_data = P1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_key = K2; in_data = P3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n, 40);
      chk("lat_after_rst", n, 10);
      chk("ct_after_rst", out_data, C3);
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
